// File: rtl/output_buffer.sv
// -----------------------------------------------------------------------------
// output_buffer
//   Write-side result buffer between the PE array and the memory write port.
//   It accepts POX result words per push into a FIFO. It drains the FIFO as
//   AXI INCR write bursts, one burst outstanding at a time, sent in the order
//   AW, then W, then B. It pulses mapend once all OW*OH words of the ofmap
//   have been acknowledged.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   init_addr[_en]       ofmap base byte address; the load also clears the
//                        counters and the error flag, and arms the block
//   result_valid/ready   PE result handshake, carrying POX words per transfer
//   result_data[POX]     result words; index 0 is the first word written
//   aw*                  write address channel (awburst is fixed to INCR)
//   w*                   write data channel
//   b*                   write response channel
//   mapend               one-cycle pulse after the last burst is acknowledged
//   err                  sticky flag for an error response; cleared by init
// -----------------------------------------------------------------------------
module output_buffer #(
  parameter int DW    = 32,
  parameter int AW    = 32,
  parameter int POX   = 16,
  parameter int BURST = 32,
  parameter int DEPTH = 64,
  parameter int OW    = 112,
  parameter int OH    = 112
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] init_addr,
  input  logic          init_addr_en,
  input  logic          result_valid,
  output logic          result_ready,
  input  logic [DW-1:0] result_data [POX],
  output logic [AW-1:0] awaddr,
  output logic [7:0]    awlen,
  output logic [1:0]    awburst,
  output logic          awvalid,
  input  logic          awready,
  output logic [DW-1:0] wdata,
  output logic          wvalid,
  input  logic          wready,
  output logic          wlast,
  input  logic          bvalid,
  input  logic [1:0]    bresp,
  output logic          bready,
  output logic          mapend,
  output logic          err
);

  localparam int MAPW = OW * OH;
  localparam int PW   = $clog2(DEPTH);
  localparam int FCW  = PW + 1;
  localparam int CW   = $clog2(MAPW + 1);
  localparam int BPB  = DW / 8;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t          state, state_next;
  logic [DW-1:0]   mem [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [FCW-1:0]  fifo_cnt;
  logic [CW-1:0]   acc_cnt;   // words accepted from the PE array
  logic [CW-1:0]   wr_cnt;    // words acknowledged on the B channel
  logic [AW-1:0]   addr;      // start address of the next burst
  logic [7:0]      beat;
  logic            armed;
  logic            push, pop, start, init_ok, map_done;
  logic [8:0]      burst_words;

  assign awburst      = 2'b01;
  assign awaddr       = addr;
  assign result_ready = armed && (fifo_cnt <= FCW'(DEPTH - POX)) && (acc_cnt < CW'(MAPW));
  assign push         = result_valid && result_ready;
  assign pop          = wvalid && wready;
  // Start a full burst when enough words are buffered. Once the whole map has
  // been accepted, flush whatever words remain as a short burst.
  assign start        = (fifo_cnt >= FCW'(BURST)) ||
                        ((acc_cnt == CW'(MAPW)) && (fifo_cnt != '0));
  // A base load is refused while a burst is about to launch.
  assign init_ok      = init_addr_en && (state == IDLE) && !start;
  assign burst_words  = {1'b0, awlen} + 9'd1;
  assign map_done     = (wr_cnt + CW'(burst_words)) == CW'(MAPW);

  assign wlast = (state == DATA) && (beat == awlen);
  assign wdata = (state == DATA) ? mem[rd_ptr] : '0;

  // NOTE: sequential state is written only with non-blocking assignments, so
  // every register sees the values from before the clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: every output of this block gets a default value first. A branch
  // that does not assign an output then cannot infer a latch.
  always_comb begin
    state_next = state;
    awvalid    = 1'b0;
    wvalid     = 1'b0;
    bready     = 1'b0;
    case (state)
      IDLE: if (start) state_next = ADDR;
      ADDR: begin
        awvalid = 1'b1;
        if (awready) state_next = DATA;
      end
      DATA: begin
        wvalid = 1'b1;
        if (wready && wlast) state_next = RESP;
      end
      RESP: begin
        bready = 1'b1;
        if (bvalid) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr     <= '0;
      awlen    <= '0;
      beat     <= '0;
      wr_cnt   <= '0;
      acc_cnt  <= '0;
      armed    <= 1'b0;
      err      <= 1'b0;
      mapend   <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      mapend <= 1'b0;
      if (init_ok) begin
        addr    <= init_addr;
        wr_cnt  <= '0;
        acc_cnt <= '0;
        err     <= 1'b0;
        armed   <= 1'b1;
      end
      // Latch the burst length at launch. Words that arrive later belong to
      // the next burst.
      if (state == IDLE && start)
        awlen <= (fifo_cnt >= FCW'(BURST)) ? 8'(BURST - 1) : 8'(fifo_cnt - 1'b1);
      if (state == ADDR && awready) beat <= '0;
      if (pop) beat <= beat + 8'd1;
      if (state == RESP && bvalid) begin
        err    <= err | (bresp != 2'b00);
        addr   <= addr + AW'(burst_words) * AW'(BPB);
        wr_cnt <= wr_cnt + CW'(burst_words);
        if (map_done) begin
          mapend <= 1'b1;
          armed  <= 1'b0;
        end
      end
      if (push) begin
        wr_ptr  <= wr_ptr + PW'(POX);
        acc_cnt <= acc_cnt + CW'(POX);
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      fifo_cnt <= fifo_cnt + (push ? FCW'(POX) : '0) - (pop ? FCW'(1) : '0);
    end
  end

  // NOTE: the storage array has no reset. An entry is only read after it has
  // been written, and keeping the array out of reset lets it map onto RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      for (int i = 0; i < POX; i++) mem[wr_ptr + PW'(i)] <= result_data[i];
    end
  end

endmodule

// File: tb/tb_output_buffer.sv
// -----------------------------------------------------------------------------
// tb_output_buffer
//   Self-checking bench for output_buffer with a small configuration:
//   POX=8, BURST=16, DEPTH=32 and an 8x9 ofmap, so MAPW=72. Each map is sent
//   as four 16-beat bursts followed by one 8-beat burst.
//   The reference model tracks the expected word stream in a queue. It
//   derives burst address and length from the count of words already issued,
//   and FIFO occupancy from the pushed and popped word counts.
// -----------------------------------------------------------------------------
module tb_output_buffer;

  localparam int DW = 32, AW = 32, POX = 8, BURST = 16, DEPTH = 32, OW = 8, OH = 9;
  localparam int MAPW = OW * OH;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] init_addr = '0;
  logic          init_addr_en = 1'b0;
  logic          result_valid = 1'b0;
  logic          result_ready;
  logic [DW-1:0] result_data [POX];
  logic [AW-1:0] awaddr;
  logic [7:0]    awlen;
  logic [1:0]    awburst;
  logic          awvalid;
  logic          awready = 1'b0;
  logic [DW-1:0] wdata;
  logic          wvalid;
  logic          wready = 1'b0;
  logic          wlast;
  logic          bvalid = 1'b0;
  logic [1:0]    bresp = 2'b00;
  logic          bready;
  logic          mapend;
  logic          err;

  always #5 clk = ~clk;

  output_buffer #(.DW(DW), .AW(AW), .POX(POX), .BURST(BURST), .DEPTH(DEPTH),
                  .OW(OW), .OH(OH)) dut (
    .clk(clk), .rst_n(rst_n), .init_addr(init_addr), .init_addr_en(init_addr_en),
    .result_valid(result_valid), .result_ready(result_ready), .result_data(result_data),
    .awaddr(awaddr), .awlen(awlen), .awburst(awburst), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wvalid(wvalid), .wready(wready), .wlast(wlast),
    .bvalid(bvalid), .bresp(bresp), .bready(bready), .mapend(mapend), .err(err)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model state ----------------
  logic [DW-1:0] exp_q [$];
  logic [AW-1:0] base_m;
  int  issued, acked, acc_m, occ, beat_m, cur_len, bursts;
  bit  armed_m, err_m, resp_pending, aw_done, mapend_pend, map_finished, b_hs_prev;
  bit  aw_stall, w_stall;
  logic [AW-1:0] awaddr_prev;
  logic [7:0]    awlen_prev;
  logic [DW-1:0] wdata_prev;
  logic          wlast_prev;
  int  aw_pct, w_pct, b_pct, rv_pct, bad_burst;

  function automatic bit chance(input int pct);
    return int'($urandom_range(99)) < pct;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    base_m = '0; issued = 0; acked = 0; acc_m = 0; occ = 0; beat_m = 0; cur_len = 0;
    bursts = 0; armed_m = 0; err_m = 0; resp_pending = 0; aw_done = 0;
    mapend_pend = 0; map_finished = 0; b_hs_prev = 0; aw_stall = 0; w_stall = 0;
  endtask

  // One clock: check the outputs, drive the next inputs, and log the
  // handshakes that will complete at the coming posedge.
  task automatic cycle(input bit do_init, input bit honoured, input logic [AW-1:0] a);
    bit exp_mapend;
    logic [DW-1:0] ew;
    @(negedge clk);
    exp_mapend = mapend_pend;
    mapend_pend = 0;
    check("mapend", mapend, exp_mapend);
    check("err", err, err_m);
    check("result_ready", result_ready,
          armed_m && (occ <= DEPTH - POX) && (acc_m < MAPW));
    if (aw_stall) begin
      check("aw_hold_valid", awvalid, 1);
      check("aw_hold_addr", awaddr, awaddr_prev);
      check("aw_hold_len", awlen, awlen_prev);
    end
    if (w_stall) begin
      check("w_hold_valid", wvalid, 1);
      check("w_hold_data", wdata, wdata_prev);
      check("w_hold_last", wlast, wlast_prev);
    end
    // drive
    init_addr_en = do_init;
    init_addr    = a;
    if (do_init && honoured) begin
      base_m = a; issued = 0; acked = 0; acc_m = 0; err_m = 0; armed_m = 1;
      map_finished = 0; bursts = 0;
    end
    awready = chance(aw_pct);
    wready  = chance(w_pct);
    if (b_hs_prev) bvalid = 1'b0;
    if (resp_pending && !bvalid) begin
      bvalid = chance(b_pct);
      bresp  = (bursts == bad_burst) ? 2'b10 : 2'b00;
    end
    result_valid = chance(rv_pct);
    foreach (result_data[i]) result_data[i] = $urandom;
    b_hs_prev = 0;
    // handshakes taking effect at the next posedge
    if (awvalid && awready) begin
      check("awaddr", awaddr, base_m + AW'(issued * (DW / 8)));
      check("awlen", awlen, (((MAPW - issued) < BURST) ? (MAPW - issued) : BURST) - 1);
      check("awburst", awburst, 2'b01);
      cur_len = int'(awlen);
      issued += int'(awlen) + 1;
      beat_m = 0;
      aw_done = 1;
    end
    if (wvalid && wready) begin
      check("w_after_aw", aw_done, 1);
      check("w_beat_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        ew = exp_q.pop_front();
        check("wdata", wdata, ew);
      end
      check("wlast", wlast, beat_m == cur_len);
      occ--;
      beat_m++;
      if (beat_m > cur_len) begin
        resp_pending = 1;
        aw_done = 0;
      end
    end
    if (bvalid && bready) begin
      check("b_expected", resp_pending, 1);
      resp_pending = 0;
      b_hs_prev = 1;
      acked += cur_len + 1;
      bursts++;
      if (bresp != 2'b00) err_m = 1;
      if (acked == MAPW) begin
        mapend_pend = 1;
        armed_m = 0;
        map_finished = 1;
      end
    end
    if (result_valid && result_ready) begin
      foreach (result_data[i]) exp_q.push_back(result_data[i]);
      occ += POX;
      acc_m += POX;
    end
    aw_stall = awvalid && !awready;
    awaddr_prev = awaddr;
    awlen_prev = awlen;
    w_stall = wvalid && !wready;
    wdata_prev = wdata;
    wlast_prev = wlast;
  endtask

  task automatic run_map(input string tag);
    int n = 0;
    while (!map_finished && n < 4000) begin
      cycle(0, 0, '0);
      n++;
    end
    check({tag, "_done_in_budget"}, map_finished, 1);
    cycle(0, 0, '0);   // mapend pulse is checked here
    cycle(0, 0, '0);   // and is expected low again here
    check({tag, "_all_words_written"}, exp_q.size(), 0);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_awaddr"}, awaddr, 0);
    check({tag, "_awlen"}, awlen, 0);
    check({tag, "_awburst"}, awburst, 2'b01);
    check({tag, "_awvalid"}, awvalid, 0);
    check({tag, "_wdata"}, wdata, 0);
    check({tag, "_wvalid"}, wvalid, 0);
    check({tag, "_wlast"}, wlast, 0);
    check({tag, "_bready"}, bready, 0);
    check({tag, "_mapend"}, mapend, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_result_ready"}, result_ready, 0);
  endtask

  task automatic set_pct(input int a, input int w, input int b, input int r, input int bad);
    aw_pct = a; w_pct = w; b_pct = b; rv_pct = r; bad_burst = bad;
  endtask

  typedef struct {
    logic [AW-1:0] base;
    int            aw, w, b, rv;
    int            bad;
    int            exp_bursts;
    bit            exp_err;
  } vec_t;

  vec_t tbl [4];

  initial begin
    int n;
    // 72 words -> four bursts of 16 plus one burst of 8 in every row
    tbl[0] = '{32'h0000_1000, 100, 100, 100, 100, -1, 5, 1'b0};
    tbl[1] = '{32'h8000_0040,  50,  40,  30,  70, -1, 5, 1'b0};
    tbl[2] = '{32'h0001_0000,  70,  60,  50,  50,  1, 5, 1'b1};
    tbl[3] = '{32'h00FF_FFC0,  30,  80,  60,  90, -1, 5, 1'b0};
    foreach (result_data[i]) result_data[i] = '0;
    model_reset();
    set_pct(0, 0, 0, 0, -1);

    #1 check_idle("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[r]) begin
      set_pct(tbl[r].aw, tbl[r].w, tbl[r].b, tbl[r].rv, tbl[r].bad);
      cycle(1, 1, tbl[r].base);
      run_map($sformatf("row%0d", r));
      check($sformatf("row%0d_bursts", r), bursts, tbl[r].exp_bursts);
      check($sformatf("row%0d_err_end", r), err, tbl[r].exp_err);
    end

    // Backpressure: results keep arriving while wready is held low.
    set_pct(100, 0, 100, 100, -1);
    cycle(1, 1, 32'h0000_2000);
    repeat (12) cycle(0, 0, '0);
    check("bp_ready_low", result_ready, 0);
    check("bp_wvalid_stalled", wvalid, 1);
    w_pct = 100;
    run_map("bp");

    // An init_addr_en pulse during DATA must be ignored.
    set_pct(80, 50, 70, 80, -1);
    cycle(1, 1, 32'h0004_0000);
    n = 0;
    while (!(aw_done && beat_m > 0) && n < 500) begin
      cycle(0, 0, '0);
      n++;
    end
    check("t6_reached_data", aw_done && beat_m > 0, 1);
    cycle(1, 0, 32'h0BAD_0000);
    run_map("t6");

    // Reset asserted in the middle of a burst.
    set_pct(100, 60, 100, 100, -1);
    cycle(1, 1, 32'h0005_0000);
    n = 0;
    while (!(aw_done && beat_m > 2) && n < 500) begin
      cycle(0, 0, '0);
      n++;
    end
    check("rst_reached_data", aw_done && beat_m > 2, 1);
    #2 rst_n = 1'b0;
    #1 check_idle("rst_mid");
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    result_valid = 1'b0; init_addr_en = 1'b0;
    model_reset();
    set_pct(0, 0, 0, 0, -1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cycle(0, 0, '0);
    check_idle("post_rst");

    // Recovery with an always-ready slave
    set_pct(100, 100, 100, 100, -1);
    cycle(1, 1, 32'h0000_0000);
    run_map("recover");
    check("recover_bursts", bursts, 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
